hp_sensor_ctrl: RTL

- Controller for a bank of N_SENS Hogge-phase glitch sensors. Each sensor has a VCC enable, a glitch-inject input and an Alarm output.
- Powers the bank up and blanks alarms during warm-up.
- Filters and latches genuine alarms and counts alarm events.
- Periodically self-tests one sensor at a time, round-robin, by injecting a glitch and checking that the sensor raises Alarm within a window.
- Sits between the sensor bank and the security/reset logic.

---
 rtl/hp_sensor_ctrl_if.sv | 35 +++
 rtl/hp_sensor_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hp_sensor_ctrl_if.sv
// Bus between hp_sensor_ctrl and the sensor bank / security logic.
// master: the controller side; slave: the bank / system side.
interface hp_sensor_ctrl_if #(
    parameter int N_SENS = 4,
    parameter int CNT_W  = 8
);
    // Signalling: there is no valid/ready pair on this bus. en is a level
    // (bank on while high), clr is a single-cycle pulse sampled on the
    // rising clock edge, alarm_in is already synchronous to the clock, and
    // every controller output is a registered level. glitch_out is the only
    // pulsed output: one-hot for exactly one cycle per self-test.
    logic              en;
    logic              clr;
    logic [N_SENS-1:0] alarm_in;
    logic              sens_vcc;
    logic [N_SENS-1:0] glitch_out;
    logic              alarm_out;
    logic [CNT_W-1:0]  alarm_cnt;
    logic              fault;
    logic [3:0]        fault_idx;
    logic [3:0]        st_sel;
    logic [2:0]        state_dbg;

    modport master (
        input  en, clr, alarm_in,
        output sens_vcc, glitch_out, alarm_out, alarm_cnt,
               fault, fault_idx, st_sel, state_dbg
    );

    modport slave (
        output en, clr, alarm_in,
        input  sens_vcc, glitch_out, alarm_out, alarm_cnt,
               fault, fault_idx, st_sel, state_dbg
    );
endinterface

// File: rtl/hp_sensor_ctrl.sv
// hp_sensor_ctrl: power-up, alarm filtering and round-robin self-test for a
// bank of Hogge-phase glitch sensors.
// Optional feature macro: HP_SELFTEST_EN. When undefined the controller
// never leaves MONITOR on the period timer, so glitch_out, fault, fault_idx
// and st_sel hold their reset value of 0 and every sensor is watched.
module hp_sensor_ctrl #(
    parameter int N_SENS    = 4,
    parameter int WARMUP    = 16,
    parameter int ST_PERIOD = 256,
    parameter int ST_WINDOW = 4,
    parameter int RECOVER   = 4,
    parameter int PERSIST   = 2,
    parameter int CNT_W     = 8
) (
    input  logic             ck,
    input  logic             rst_n,
    hp_sensor_ctrl_if.master bus
);
    localparam int TMAX01 = (WARMUP > ST_PERIOD) ? WARMUP : ST_PERIOD;
    localparam int TMAX23 = (ST_WINDOW > RECOVER) ? ST_WINDOW : RECOVER;
    localparam int TMAX   = (TMAX01 > TMAX23) ? TMAX01 : TMAX23;
    localparam int TW     = $clog2(TMAX + 1);
    localparam int PW     = $clog2(PERSIST + 1);
    localparam int NW     = $clog2(N_SENS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WARMUP, S_MONITOR, S_INJECT, S_CHECK, S_RECOV
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [3:0]        sel_q, sel_d;
    logic              sens_vcc_q, sens_vcc_d;
    logic [N_SENS-1:0] glitch_q, glitch_d;
    logic [PW-1:0]     pc_q [N_SENS];
    logic [PW-1:0]     pc_d [N_SENS];
    logic [N_SENS-1:0] qual;
    logic [NW-1:0]     n_qual;
    logic              alarm_q, alarm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_base;
    logic [CNT_W:0]    cnt_sum;
    logic              fault_q, fault_d;
    logic [3:0]        fidx_q, fidx_d;
    logic              fault_set;
    logic              active, busy;
`ifdef HP_SELFTEST_EN
    logic              sel_alarm;
`endif

    // The bank is watched from MONITOR onwards; the sensor under test is
    // blanked for the whole inject/check/recover sequence.
    assign active = bus.en && (state_q inside {S_MONITOR, S_INJECT, S_CHECK, S_RECOV});
    assign busy   = state_q inside {S_INJECT, S_CHECK, S_RECOV};

`ifdef HP_SELFTEST_EN
    // Response of the selected sensor, picked without an oversized index.
    always_comb begin
        sel_alarm = 1'b0;
        for (int i = 0; i < N_SENS; i++)
            if (sel_q == 4'(i)) sel_alarm = bus.alarm_in[i];
    end
`endif

    // Next-state and self-test control.
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        sel_d     = sel_q;
        glitch_d  = '0;
        fault_set = 1'b0;
        if (!bus.en) begin
            state_d = S_IDLE;
            tmr_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_WARMUP;
                    tmr_d   = TW'(WARMUP - 1);
                end
                S_WARMUP: begin
                    if (tmr_q == '0) begin
                        state_d = S_MONITOR;
                        tmr_d   = TW'(ST_PERIOD - 1);
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                S_MONITOR: begin
`ifdef HP_SELFTEST_EN
                    if (tmr_q == '0) begin
                        state_d  = S_INJECT;
                        glitch_d = N_SENS'(1) << sel_q;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
`endif
                end
`ifdef HP_SELFTEST_EN
                S_INJECT: begin
                    state_d = S_CHECK;
                    tmr_d   = TW'(ST_WINDOW - 1);
                end
                S_CHECK: begin
                    if (sel_alarm) begin
                        state_d = S_RECOV;
                        tmr_d   = TW'(RECOVER - 1);
                    end else if (tmr_q == '0) begin
                        fault_set = 1'b1;
                        state_d   = S_RECOV;
                        tmr_d     = TW'(RECOVER - 1);
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                S_RECOV: begin
                    if (tmr_q == '0) begin
                        state_d = S_MONITOR;
                        tmr_d   = TW'(ST_PERIOD - 1);
                        sel_d   = (sel_q == 4'(N_SENS - 1)) ? 4'd0 : sel_q + 4'd1;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
        sens_vcc_d = (state_d != S_IDLE);
    end

    // Per-sensor persistence: one qualifying event per assertion run.
    always_comb begin
        qual   = '0;
        n_qual = '0;
        for (int i = 0; i < N_SENS; i++) begin
            pc_d[i] = '0;
            if (active && !(busy && sel_q == 4'(i)) && bus.alarm_in[i]) begin
                if (pc_q[i] == PW'(PERSIST - 1)) qual[i] = 1'b1;
                pc_d[i] = (pc_q[i] == PW'(PERSIST)) ? pc_q[i] : pc_q[i] + 1'b1;
            end
            n_qual = n_qual + NW'(qual[i]);
        end
    end

    // Sticky flags and saturating counter; a new event beats a coincident clr.
    always_comb begin
        cnt_base = bus.clr ? '0 : cnt_q;
        cnt_sum  = {1'b0, cnt_base} + (CNT_W + 1)'(n_qual);
        cnt_d    = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        alarm_d  = (n_qual != '0) ? 1'b1 : (bus.clr ? 1'b0 : alarm_q);
        fault_d  = fault_set ? 1'b1 : (bus.clr ? 1'b0 : fault_q);
        fidx_d   = fault_set ? sel_q : fidx_q;
    end

    // FSM state, shared timer and self-test selection.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tmr_q      <= '0;
            sel_q      <= '0;
            sens_vcc_q <= 1'b0;
            glitch_q   <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            sel_q      <= sel_d;
            sens_vcc_q <= sens_vcc_d;
            glitch_q   <= glitch_d;
        end
    end

    // Alarm filtering, counter and fault registers.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '{default: '0};
            alarm_q <= 1'b0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            fidx_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            alarm_q <= alarm_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            fidx_q  <= fidx_d;
        end
    end

    assign bus.sens_vcc   = sens_vcc_q;
    assign bus.glitch_out = glitch_q;
    assign bus.alarm_out  = alarm_q;
    assign bus.alarm_cnt  = cnt_q;
    assign bus.fault      = fault_q;
    assign bus.fault_idx  = fidx_q;
    assign bus.st_sel     = sel_q;
    assign bus.state_dbg  = state_q;
endmodule
